// File: rtl/fsm_ctrl_pkg.sv
// Shared types and defaults for the sequence-detector step controller.
// Holds mode/state enums, default parameters and the mode-entry helper.
package fsm_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        RUN     = 2'b01,
        STEP    = 2'b10,
        PATTERN = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN_S,
        STEP_S,
        PAT_WAIT,
        PLAY,
        FIN
    } state_t;

    localparam int DEF_DIV    = 3;
    localparam int DEF_PAT_W  = 8;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_DB_CYC = 4;

    function automatic state_t entry_state(input mode_t m);
        state_t s;
        s = IDLE;
        case (m)
            HOLD:    s = IDLE;
            RUN:     s = RUN_S;
            STEP:    s = STEP_S;
            PATTERN: s = PAT_WAIT;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fsm_step_controller_sync_debounce.sv
// Two-flop synchronizer with optional debounce (DB_CYC=0 -> sync only).
// Ports: clk, rst (async active-low), din (raw async), dout (conditioned).
module sync_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    generate
        if (DB_CYC == 0) begin : g_sync
            assign dout = s2_q;
        end else begin : g_db
            localparam int CW = $clog2(DB_CYC + 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          out_q;
            logic          out_d;

            // cnt tracks how many consecutive samples disagree with out_q;
            // the output flips on the DB_CYC-th such sample.
            always_comb begin
                cnt_d = '0;
                out_d = out_q;
                if (s2_q != out_q) begin
                    if (cnt_q == CW'(DB_CYC - 1)) begin
                        out_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    out_q <= out_d;
                end
            end

            assign dout = out_q;
        end
    endgenerate

endmodule

// File: rtl/fsm_step_controller.sv
// Single-clock step sequencer for the board sequence-detector FSM.
// Ports: clk, rst (async low), mode, step_btn, sw_x, pat_load, pattern,
// det_z in; det_x, step_en, det_clr, busy, pat_done, step_cnt, hit_cnt out.
module fsm_step_controller
    import fsm_ctrl_pkg::*;
#(
    parameter int DIV    = DEF_DIV,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DB_CYC = DEF_DB_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             sw_x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             det_z,
    output logic             det_x,
    output logic             step_en,
    output logic             det_clr,
    output logic             busy,
    output logic             pat_done,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int PW = $clog2(DIV);
    localparam int BW = $clog2(PAT_W + 1);

    logic btn_db;
    logic x_sync;
    logic ld_sync;

    sync_debounce #(.DB_CYC(DB_CYC)) u_btn (
        .clk  (clk),
        .rst  (rst),
        .din  (step_btn),
        .dout (btn_db)
    );

    sync_debounce #(.DB_CYC(0)) u_x (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_x),
        .dout (x_sync)
    );

    sync_debounce #(.DB_CYC(0)) u_ld (
        .clk  (clk),
        .rst  (rst),
        .din  (pat_load),
        .dout (ld_sync)
    );

    mode_t            mode_q;
    mode_t            mode_prev_q;
    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic [PAT_W-1:0] sh_q;
    logic [PAT_W-1:0] sh_d;
    logic [BW-1:0]    bit_q;
    logic [BW-1:0]    bit_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             samp_q;
    logic             samp_d;
    logic             btn_prev_q;
    logic             ld_prev_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic [CNT_W-1:0] step_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;

    logic mode_chg;
    logic counting;
    logic tick;
    logic btn_rise;
    logic ld_rise;
    logic clr_cnt;

    assign mode_chg = (mode_q != mode_prev_q);
    assign counting = (state_q == RUN_S) || (state_q == PLAY);
    assign tick     = counting && (pre_q == PW'(DIV - 1));
    assign btn_rise = btn_db & ~btn_prev_q;
    assign ld_rise  = ld_sync & ~ld_prev_q;

    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        sh_d    = sh_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step_en = 1'b0;
        det_clr = 1'b0;
        clr_cnt = 1'b0;

        if (counting && !tick) begin
            pre_d = pre_q + 1'b1;
        end

        // A mode change outranks any tick or edge in the same cycle.
        if (mode_chg) begin
            state_d = entry_state(mode_q);
            pre_d   = '0;
            busy_d  = 1'b0;
            det_clr = 1'b1;
            clr_cnt = 1'b1;
        end else begin
            unique case (state_q)
                RUN_S: begin
                    step_en = tick;
                end
                STEP_S: begin
                    step_en = btn_rise;
                end
                PAT_WAIT: begin
                    if (ld_rise) begin
                        sh_d    = pattern;
                        bit_d   = BW'(PAT_W);
                        det_clr = 1'b1;
                        clr_cnt = 1'b1;
                        busy_d  = 1'b1;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        step_en = 1'b1;
                        sh_d    = sh_q << 1;
                        bit_d   = bit_q - 1'b1;
                        if (bit_q == BW'(1)) begin
                            state_d = FIN;
                        end
                    end
                end
                FIN: begin
                    // Last hit sample lands here; completion pulses next.
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = PAT_WAIT;
                end
                default: begin
                end
            endcase
        end

        samp_d = step_en;

        step_cnt_d = step_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        if (clr_cnt) begin
            step_cnt_d = '0;
            hit_cnt_d  = '0;
        end else begin
            if (step_en && !(&step_cnt_q)) begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
            if (samp_q && det_z && !(&hit_cnt_q)) begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        det_x = 1'b0;
        unique case (state_q)
            RUN_S, STEP_S:       det_x = x_sync;
            PAT_WAIT, PLAY, FIN: det_x = sh_q[PAT_W-1];
            default:             det_x = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= HOLD;
            mode_prev_q <= HOLD;
            state_q     <= IDLE;
            pre_q       <= '0;
            sh_q        <= '0;
            bit_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            samp_q      <= 1'b0;
            btn_prev_q  <= 1'b0;
            ld_prev_q   <= 1'b0;
            step_cnt_q  <= '0;
            hit_cnt_q   <= '0;
        end else begin
            mode_q      <= mode_t'(mode);
            mode_prev_q <= mode_q;
            state_q     <= state_d;
            pre_q       <= pre_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            samp_q      <= samp_d;
            btn_prev_q  <= btn_db;
            ld_prev_q   <= ld_sync;
            step_cnt_q  <= step_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign pat_done = done_q;
    assign step_cnt = step_cnt_q;
    assign hit_cnt  = hit_cnt_q;

endmodule

// File: doc/fsm_step_controller.md
Name: fsm_step_controller

Overview:
- Sequencer for the board-level sequence-detector FSM.
- Replaces the derived-clock scheme with a single-clock step enable, so the detector runs on clk and advances only on step_en.
- Supplies the detector's x input from a switch or from a loaded bit pattern, and runs hold, free-run, single-step and pattern-playback modes.
- Counts steps and detections for LED/7-seg display.

Parameters:
- DIV, 3: prescaler period in clk cycles between run-mode steps; must be >= 2.
- PAT_W, 8: playback pattern width.
- CNT_W, 8: width of step and hit counters.
- DB_CYC, 4: debounce stable-cycle count for step_btn.

Ports:
- clk  in  1  system clock (CLOCK_50 on board).
- rst  in  1  asynchronous, active-low reset.
- mode  in  2  00 HOLD, 01 RUN, 10 STEP, 11 PATTERN; treated as quasi-static and registered once.
- step_btn  in  1  raw push-button, active-high, asynchronous.
- sw_x  in  1  raw switch providing x in RUN/STEP, asynchronous.
- pat_load  in  1  raw level; a synced rising edge starts playback.
- pattern  in  PAT_W  playback bits, played MSB first; sampled on load.
- det_z  in  1  detector Moore output.
- det_x  out  1  x to detector.
- step_en  out  1  one-cycle detector advance enable.
- det_clr  out  1  one-cycle synchronous clear to detector (active-high; forces s0).
- busy  out  1  pattern playback in progress.
- pat_done  out  1  one-cycle pulse at playback completion.
- step_cnt  out  CNT_W  steps issued, saturating.
- hit_cnt  out  CNT_W  det_z samples equal to 1, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state IDLE; prescaler 0; shift register 0.
- Input conditioning:
  - step_btn, sw_x and pat_load each pass through a 2-flop synchronizer.
  - step_btn is then debounced: the output changes only after DB_CYC consecutive equal samples.
  - Rising-edge detect on debounced step_btn and on synced pat_load.
- Prescaler:
  - Counts 0..DIV-1 only in RUN; tick when count==DIV-1, then wraps to 0.
  - Held at 0 in all other states.
  - PATTERN playback uses the same prescaler, also counting in PLAY.
- Mode change: a registered mode differing from its previous value does the following in one cycle:
  - Pulses det_clr.
  - Clears both counters and the prescaler.
  - Aborts playback (busy=0, no pat_done).
  - Enters that mode's entry state.
- States and transitions:
  - IDLE: mode HOLD; no steps.
  - RUN: step_en = tick.
  - STEP: step_en = debounced button rising edge.
  - PAT_WAIT: in PATTERN with no playback. On pat_load edge:
    - load shift register from pattern;
    - bit counter := PAT_W;
    - pulse det_clr;
    - clear counters;
    - busy:=1;
    - go to PLAY.
  - PLAY: on tick, step_en=1, shift left, decrement bit counter. When the counter reaches 0 after its step, go to FIN.
  - FIN: one cycle for the final hit sample, then pat_done=1 for 1 cycle, busy:=0, back to PAT_WAIT.
- det_x:
  - RUN/STEP: synced sw_x.
  - PAT_WAIT/PLAY/FIN: shift register MSB.
  - IDLE: 0.
  - Must be stable in the cycle step_en is high.
- Counting:
  - step_cnt increments on each step_en.
  - det_z is sampled exactly 1 cycle after each step_en; hit_cnt increments if det_z=1.
  - Both counters saturate at 2^CNT_W-1 with no wrap.
- Ignored events: pat_load edge while busy; button edge outside STEP.
- Simultaneous events: a mode change and a tick in the same cycle resolve as the mode change, with no step.
- det_clr and step_en are never asserted in the same cycle.

Decomposition:
- Package fsm_ctrl_pkg holds:
  - mode_t enum (HOLD, RUN, STEP, PATTERN);
  - state_t enum (IDLE, RUN_S, STEP_S, PAT_WAIT, PLAY, FIN);
  - default constants for DIV, PAT_W, CNT_W, DB_CYC.
- One sub-module, sync_debounce:
  - 2-flop synchronizer plus DB_CYC debounce, parameterised;
  - instantiated for step_btn;
  - sw_x and pat_load use its synchronizer-only configuration (DB_CYC=0).

Test Plan:
All scenarios use a DIV=3 bench with the team's sequence detector attached (s0→s1→s3→s5 on x=1,1,1; z=1 in s5).
- Reset: rst=0 mid-PLAY → all outputs 0 immediately; after release with mode=HOLD, no step_en for 50 cycles.
- PATTERN, pattern=8'b1110_0000, pulse pat_load → 8 step_en exactly 3 cycles apart, det_x sequence 1,1,1,0,0,0,0,0, hit_cnt=1, step_cnt=8, pat_done single pulse, busy low after.
- PATTERN, pattern=8'hFF → hit_cnt=2 (hits after steps 3 and 6), step_cnt=8.
- STEP, sw_x=1, three clean button presses plus one 2-cycle glitch → exactly 3 step_en; hit_cnt=1; glitch produces none.
- Mode change PATTERN→RUN after 4 steps of playback → det_clr pulse, counters 0, busy 0, no pat_done; RUN steps then every 3 cycles.
- Saturation: CNT_W=2, RUN for 10 ticks → step_cnt holds at 3; second pat_load while busy is ignored (playback not restarted).
